uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single byte-wide UART transmitter between several report sources (temperature reporter, status/LED reporter, debug).
Each requester presents a framed byte stream (valid/ready/last). The arbiter locks the transmitter to one requester until that frame's last byte is accepted, so frames never interleave.
It sits between the report producers and the uart_tx byte front-end, on the 12 MHz system clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width per transfer
MAX_FRAME_LEN, 16, maximum bytes per frame before forced release (1..255)

Ports:
clk  input  1  12 MHz system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  marks final byte of the frame
req_ready  output  NUM_REQ  per-requester accept; only the granted bit can be 1
tx_valid  output  1  byte valid to the transmitter
tx_data  output  DATA_WIDTH  byte to the transmitter
tx_ready  input  1  transmitter accepts byte (transfer = tx_valid & tx_ready)
grant_id  output  clog2(NUM_REQ)  index of the current owner; held after release
busy  output  1  high while a frame is owned
overrun  output  1  one-cycle pulse on forced release
overrun_id  output  clog2(NUM_REQ)  sticky index of the last overrun requester

Behaviour:
- Reset (async, rst_n=0): state IDLE; grant_id=0; busy=0; overrun=0; overrun_id=0; pointer last_grant=NUM_REQ-1, so req 0 wins first. tx_valid and req_ready are forced 0 immediately, without waiting for a clock edge.
- States: IDLE, GRANT; plus TAG when the optional feature is compiled in.
- IDLE:
  - tx_valid=0; req_ready=0.
  - If any req_valid is high, pick the first set bit searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Register grant_id; set busy=1; go to GRANT.
  - Arbitration latency: 1 cycle from req_valid to tx_valid.
- GRANT (owner g):
  - tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready. These are combinational from registered g.
  - All other req_ready bits are 0.
  - The owner may insert bubbles (req_valid[g]=0); the grant is held.
- Byte counter: cleared on entry to GRANT; increments on each transfer. Width is clog2(MAX_FRAME_LEN+1).
- Transfer with req_last[g]=1: go to IDLE; last_grant=g; busy=0.
  - Re-arbitration takes 1 IDLE cycle, so back-to-back frames have a 1-cycle gap.
- Forced release: a transfer that makes count==MAX_FRAME_LEN without last causes:
  - overrun pulse for 1 cycle; overrun_id=g; go to IDLE; last_grant=g.
  - Any remaining bytes from g compete as a new frame.
- Simultaneous last and count limit on the same byte: normal release; no overrun.
- Requests arriving during GRANT wait. Non-owner valid bytes are never lost, because their ready stays 0.
- While tx_ready=0, tx_data follows the owner's req_data. The owner must hold its data stable; the arbiter adds no buffering.

Optional Feature:
Macro UART_ARB_TAG_EN.
- Defined: IDLE goes to TAG instead of GRANT.
  - TAG drives tx_valid=1, tx_data=8'hA0 | grant_id, req_ready=0.
  - On tx_ready, go to GRANT.
  - The tag is not counted toward MAX_FRAME_LEN.
  - Latency from request to first payload byte: 1 cycle plus the tag transfer.
- Undefined: no TAG state; payload bytes only.

Decomposition:
- Package uart_arb_pkg holds:
  - state encodings IDLE/TAG/GRANT
  - TAG_BASE=8'hA0
  - a width function for grant_id and the counter
- One combinational sub-module, rr_pick: inputs are a request vector and a pointer; outputs are winner index and any_req. It is instantiated once in IDLE.

Test Plan:
All tests use NUM_REQ=4, MAX_FRAME_LEN=16.
- Single frame: after reset, req0 sends 0x41 with last and tx_ready=1 -> tx_valid rises 1 cycle after req_valid; tx_data=0x41; grant_id=0; busy drops the cycle after the transfer.
- Contention: all 4 requesters hold 2-byte frames {0x10+i, 0x20+i} -> tx stream is 10,20,11,21,12,22,13,23, then 10,20 again. No interleaving; 1 idle cycle between frames.
- Backpressure: tx_ready=0 for 5 cycles mid-frame of req1 -> req_ready[1]=0 and tx_data stable for those 5 cycles; byte count at the sink equals the count sent.
- Overrun: req2 streams 20 bytes with no last; req3 also pending -> after the 16th byte, overrun=1 for 1 cycle, overrun_id=2, the next grant goes to req3, and req2 then resumes with byte 17.
- Reset mid-frame: rst_n=0 during byte 3 of req1 -> tx_valid=0 combinationally. After release, with req0 and req1 pending, req0 wins.
- UART_ARB_TAG_EN: req1 sends 0x55 with last -> sink sees 0xA1 then 0x55; a 16-byte frame from req1 with the tag does not trigger overrun.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the frame tag base byte and an index-width helper.
// No ports (package).
// Optional feature macro: UART_ARB_TAG_EN (ST_TAG is only entered when defined).
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TAG   = 2'd1,
        ST_GRANT = 2'd2
    } arb_state_e;

    localparam logic [7:0] TAG_BASE = 8'hA0;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first set request bit
// searching ptr_i+1, ptr_i+2, ... modulo N.
// Ports:
//   req_i  [N-1:0]  request vector
//   ptr_i  [W-1:0]  index of the previous winner
//   idx_o  [W-1:0]  winning index (0 when no request)
//   any_o           at least one request is set
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [W-1:0] j;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = W'((32'(ptr_i) + k) % N);
            if (!any_o && req_i[j]) begin
                any_o = 1'b1;
                idx_o = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one byte-wide UART transmitter between
// NUM_REQ framed byte sources. The transmitter stays locked to one
// requester until its last byte is accepted, or until MAX_FRAME_LEN bytes
// pass without last (forced release, flagged by overrun).
// Optional feature macro: UART_ARB_TAG_EN -- when defined, each frame is
// preceded by a tag byte (TAG_BASE | grant_id) that does not count toward
// MAX_FRAME_LEN.
// Ports:
//   clk, rst_n       12 MHz clock, asynchronous active-low reset
//   req_valid/last   per-requester valid and end-of-frame marker
//   req_data         packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready        per-requester accept, only the owner's bit can be set
//   tx_valid/data    byte to the transmitter
//   tx_ready         transmitter accepts (transfer = tx_valid & tx_ready)
//   grant_id         current/last owner, held after release
//   busy             a frame is owned
//   overrun          one-cycle pulse on forced release
//   overrun_id       sticky index of the last overrun requester
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned MAX_FRAME_LEN = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               tx_valid,
    output logic [DATA_WIDTH-1:0]              tx_data,
    input  logic                               tx_ready,
    output logic [idx_width(NUM_REQ)-1:0]      grant_id,
    output logic                               busy,
    output logic                               overrun,
    output logic [idx_width(NUM_REQ)-1:0]      overrun_id
);

    localparam int unsigned    IW        = idx_width(NUM_REQ);
    localparam int unsigned    CW        = idx_width(MAX_FRAME_LEN + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(MAX_FRAME_LEN);

    arb_state_e              state_q;
    logic [IW-1:0]           grant_q;
    logic [IW-1:0]           last_q;
    logic [IW-1:0]           ovr_id_q;
    logic [CW-1:0]           cnt_q;
    logic                    busy_q;
    logic                    ovr_q;

    logic [IW-1:0]           pick_idx;
    logic                    pick_any;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    owner_valid;
    logic                    owner_last;
    logic                    xfer;

    rr_pick #(
        .N (NUM_REQ),
        .W (IW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (last_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_valid = req_valid[grant_q];
    assign owner_last  = req_last[grant_q];
    assign xfer        = (state_q == ST_GRANT) && owner_valid && tx_ready;

    // Datapath is combinational from the registered owner; the async reset
    // of state_q drops tx_valid/req_ready without waiting for a clock.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state_q)
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                tx_valid = 1'b1;
                tx_data  = DATA_WIDTH'(TAG_BASE) | DATA_WIDTH'(grant_q);
            end
`endif
            ST_GRANT: begin
                tx_valid           = owner_valid;
                tx_data            = owner_data;
                req_ready[grant_q] = tx_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= IW'(NUM_REQ - 1);
            ovr_id_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
`ifdef UART_ARB_TAG_EN
                        state_q <= ST_TAG;
`else
                        state_q <= ST_GRANT;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                ST_TAG: begin
                    if (tx_ready) begin
                        state_q <= ST_GRANT;
                    end
                end
`endif
                ST_GRANT: begin
                    if (xfer) begin
                        // last wins over the length limit: no overrun then
                        if (owner_last || (cnt_q + CW'(1) == CNT_LIMIT)) begin
                            state_q <= ST_IDLE;
                            last_q  <= grant_q;
                            busy_q  <= 1'b0;
                            if (!owner_last) begin
                                ovr_q    <= 1'b1;
                                ovr_id_q <= grant_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign overrun_id = ovr_id_q;

endmodule
